// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared types and helpers for the FC result classifier
// Purpose: FSM state encoding, class-index width helper and saturation bounds
//          used by fc_result_classifier, its interface and fc_requant_sat.
// Ports: none (package).
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } fc_state_t;

    // Width of the class index; a single class bit is kept even for two classes.
    function automatic int fc_cw(input int num_classes);
        return (num_classes <= 2) ? 1 : $clog2(num_classes);
    endfunction

    // Largest signed value representable in bitwidth bits.
    function automatic int fc_sat_max(input int bitwidth);
        return (1 << (bitwidth - 1)) - 1;
    endfunction

    // Smallest signed value representable in bitwidth bits.
    function automatic int fc_sat_min(input int bitwidth);
        return -(1 << (bitwidth - 1));
    endfunction

endpackage

// File: rtl/fc_result_classifier_if.sv
// rtl/fc_result_classifier_if.sv - input/output handshake bundle of the classifier
// Purpose: groups the result capture handshake and the classification output.
// Ports (signals):
//   in_valid/in_ready/in_result          packed signed 2*BITWIDTH results in
//   out_valid/out_ready                  classification handshake
//   out_class/out_score/out_act          argmax index, max score, requantized vector
// Modports: master = producer/consumer side, slave = classifier side.
interface fc_result_classifier_if #(
    parameter int BITWIDTH    = 8,
    parameter int NUM_CLASSES = 2
);
    import fc_pkg::*;

    localparam int CW = fc_cw(NUM_CLASSES);

    logic                              in_valid;
    logic                              in_ready;
    logic [2*BITWIDTH*NUM_CLASSES-1:0] in_result;
    logic                              out_valid;
    logic                              out_ready;
    logic [CW-1:0]                     out_class;
    logic [BITWIDTH-1:0]               out_score;
    logic [BITWIDTH*NUM_CLASSES-1:0]   out_act;

    modport master (
        output in_valid,
        output in_result,
        input  in_ready,
        input  out_valid,
        output out_ready,
        input  out_class,
        input  out_score,
        input  out_act
    );

    modport slave (
        input  in_valid,
        input  in_result,
        output in_ready,
        output out_valid,
        input  out_ready,
        output out_class,
        output out_score,
        output out_act
    );

endinterface

// File: rtl/fc_requant_sat.sv
// rtl/fc_requant_sat.sv - requantize one FC result: shift, saturate, optional ReLU
// Purpose: arithmetic right shift by SHIFT at full 2*BITWIDTH width, then
//          saturate to signed BITWIDTH. With FC_CLASSIFIER_RELU_EN defined the
//          result is additionally clamped to a minimum of 0.
// Ports:
//   din   in   2*BITWIDTH  signed FC result
//   dout  out  BITWIDTH    signed requantized value
module fc_requant_sat
    import fc_pkg::*;
#(
    parameter int BITWIDTH = 8,
    parameter int SHIFT    = 4
) (
    input  logic signed [2*BITWIDTH-1:0] din,
    output logic signed [BITWIDTH-1:0]   dout
);

    localparam int EW = 2 * BITWIDTH;
    localparam logic signed [EW-1:0] MAXV = EW'(fc_sat_max(BITWIDTH));
    localparam logic signed [EW-1:0] MINV = EW'(fc_sat_min(BITWIDTH));

    logic signed [EW-1:0] shifted;

    assign shifted = din >>> SHIFT;

    always_comb begin
        dout = shifted[BITWIDTH-1:0];
        if (shifted > MAXV) begin
            dout = MAXV[BITWIDTH-1:0];
        end else if (shifted < MINV) begin
            dout = MINV[BITWIDTH-1:0];
        end
`ifdef FC_CLASSIFIER_RELU_EN
        if (dout[BITWIDTH-1]) begin
            dout = '0;
        end
`else
`endif
    end

endmodule

// File: rtl/fc_result_classifier.sv
// rtl/fc_result_classifier.sv - FC layer output requantizer and argmax classifier
// Purpose: captures a packed vector of NUM_CLASSES signed 2*BITWIDTH results,
//          requantizes one element per cycle and tracks the argmax, then holds
//          class, score and requantized vector until the consumer accepts.
//          Optional ReLU clamp: define FC_CLASSIFIER_RELU_EN.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of fc_result_classifier_if (in_*/out_* handshakes)
module fc_result_classifier
    import fc_pkg::*;
#(
    parameter int BITWIDTH    = 8,
    parameter int NUM_CLASSES = 2,
    parameter int SHIFT       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    fc_result_classifier_if.slave  bus
);

    localparam int EW = 2 * BITWIDTH;
    localparam int CW = fc_cw(NUM_CLASSES);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_CLASSES - 1);

    fc_state_t state, state_next;

    logic [CW-1:0]                   idx;
    logic [EW*NUM_CLASSES-1:0]       cap;
    logic signed [EW-1:0]            elem;
    logic signed [BITWIDTH-1:0]      q;
    logic signed [BITWIDTH-1:0]      score;
    logic [CW-1:0]                   cls;
    logic [BITWIDTH*NUM_CLASSES-1:0] act;
    logic                            accept;
    logic                            is_last;

    assign elem    = cap[idx*EW +: EW];
    assign is_last = (idx == LAST_IDX);

    fc_requant_sat #(
        .BITWIDTH (BITWIDTH),
        .SHIFT    (SHIFT)
    ) u_requant (
        .din  (elem),
        .dout (q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept     = 1'b1;
                    state_next = SCAN;
                end
            end
            SCAN: begin
                if (is_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                // in_ready stays low here so an output handshake never
                // overlaps with a new capture.
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap   <= '0;
            idx   <= '0;
            score <= '0;
            cls   <= '0;
            act   <= '0;
        end else begin
            if (accept) begin
                cap <= bus.in_result;
                idx <= '0;
            end
            if (state == SCAN) begin
                act[idx*BITWIDTH +: BITWIDTH] <= q;
                // Strictly-greater update keeps the lowest index on ties.
                if ((idx == '0) || (q > score)) begin
                    score <= q;
                    cls   <= idx;
                end
                if (!is_last) begin
                    idx <= idx + 1'b1;
                end
            end
        end
    end

    // Outputs come straight from registers; DONE is itself a registered state.
    assign bus.out_valid = (state == DONE);
    assign bus.out_class = cls;
    assign bus.out_score = score;
    assign bus.out_act   = act;

endmodule

// File: tb/tb_fc_result_classifier.sv
// tb/tb_fc_result_classifier.sv - directed bench for fc_result_classifier
module tb_fc_result_classifier;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fc_result_classifier_if #(.BITWIDTH(8), .NUM_CLASSES(2)) bus ();

    fc_result_classifier #(
        .BITWIDTH    (8),
        .NUM_CLASSES (2),
        .SHIFT       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int e_cls, input int e_score, input int e_act);
        chk({tag, "_class"}, int'(bus.out_class), e_cls);
        chk({tag, "_score"}, int'($signed(bus.out_score)), e_score);
        chk({tag, "_act"}, int'(bus.out_act), e_act);
    endtask

    // Present a vector, count edges to out_valid, compare outputs, then handshake.
    task automatic run_vec(input string tag, input logic [15:0] e0, input logic [15:0] e1,
                           input int e_cls, input int e_score, input int e_act);
        int edges;
        chk({tag, "_in_ready"}, int'(bus.in_ready), 1);
        bus.in_valid  = 1'b1;
        bus.in_result = {e1, e0};
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.in_result = 32'hDEAD_BEEF;
        edges = 0;
        while (!bus.out_valid && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk({tag, "_latency"}, edges, 2);
        chk_out(tag, e_cls, e_score, e_act);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk({tag, "_valid_clr"}, int'(bus.out_valid), 0);
        chk({tag, "_ready_back"}, int'(bus.in_ready), 1);
    endtask

    initial begin
        int edges;
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_result = '0;
        bus.out_ready = 1'b0;
        #2;
        chk("rst_valid", int'(bus.out_valid), 0);
        chk("rst_ready", int'(bus.in_ready), 1);
        chk_out("rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_vec("basic", 16'h0100, 16'h0050, 0, 16, 'h0510);
        run_vec("sat_hi", 16'h0100, 16'h7FFF, 1, 127, 'h7F10);
`ifdef FC_CLASSIFIER_RELU_EN
        run_vec("sat_lo", 16'h8000, 16'h0000, 0, 0, 'h0000);
        run_vec("tie", 16'h0040, 16'h0040, 0, 4, 'h0404);
        run_vec("neg", 16'hFF00, 16'hFFE0, 0, 0, 'h0000);
`else
        run_vec("sat_lo", 16'h8000, 16'h0000, 1, 0, 'h0080);
        run_vec("tie", 16'h0040, 16'h0040, 0, 4, 'h0404);
        run_vec("neg", 16'hFF00, 16'hFFE0, 1, -2, 'hFEF0);
`endif

        // Backpressure: vector A waits in DONE while vector B is offered.
        bus.in_valid  = 1'b1;
        bus.in_result = {16'h0020, 16'h0300};
        @(posedge clk);
        #1;
        bus.in_result = {16'h0200, 16'h0010};
        edges = 0;
        while (!bus.out_valid && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("bp_latency", edges, 2);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", int'(bus.out_valid), 1);
            chk("bp_in_ready", int'(bus.in_ready), 0);
            chk_out("bp_hold", 0, 48, 'h0230);
            @(posedge clk);
            #1;
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        chk("bp_rel_valid", int'(bus.out_valid), 0);
        chk("bp_rel_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk("bp_b_taken", int'(bus.in_ready), 0);
        edges = 0;
        while (!bus.out_valid && edges < 10) begin
            @(posedge clk);
            #1;
            edges++;
        end
        chk("bp_b_latency", edges, 2);
        chk_out("bp_b", 1, 32, 'h2001);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;

        // Reset one cycle into SCAN discards the partial result.
        bus.in_valid  = 1'b1;
        bus.in_result = {16'h0100, 16'h0200};
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", int'(bus.out_valid), 0);
        chk("mid_rst_ready", int'(bus.in_ready), 1);
        chk_out("mid_rst", 0, 0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_vec("post_rst", 16'h0030, 16'h0070, 1, 7, 'h0703);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
